// File: rtl/nios2_cpu_ocimem_arbiter_pkg.sv
// Shared types and constants for the OCI RAM arbiter slice.
package nios2_ocimem_pkg;

    localparam int OCI_DATA_W    = 32;
    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RD_BIT    = 34;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

    typedef enum logic [2:0] {
        IDLE,
        J_WR,
        J_RD,
        J_CAP,
        A_WR,
        A_RD,
        A_CAP
    } ocimem_state_t;

    function automatic logic is_jtag_state(ocimem_state_t s);
        return s inside {J_WR, J_RD, J_CAP};
    endfunction

endpackage

// File: rtl/nios2_cpu_ocimem_arbiter_if.sv
// Avalon debug_mem_slave bus between the CPU side and the OCI RAM arbiter.
interface nios2_cpu_ocimem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic              debugaccess;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable, debugaccess,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable, debugaccess,
        output readdata, waitrequest
    );
endinterface

// File: rtl/nios2_cpu_ocimem_arbiter_rr_grant.sv
// Two-requester selector: fixed JTAG priority or round-robin on conflicts.
module nios2_ocimem_rr_grant #(
    parameter int JTAG_PRIO = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_j,
    input  logic req_a,
    output logic gnt_j,
    output logic gnt_a
);
    logic prefer_j;

    // JTAG wins when alone, when favoured by the pointer, or always in priority mode
    always_comb begin
        gnt_j = req_j & (~req_a | prefer_j | (JTAG_PRIO != 0));
        gnt_a = req_a & ~gnt_j;
    end

    // Pointer moves only on a real conflict, away from the side just served
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prefer_j <= 1'b1;
        end else if (req_j && req_a) begin
            prefer_j <= gnt_a;
        end
    end
endmodule

// File: rtl/nios2_cpu_ocimem_arbiter.sv
// Shares the single-port OCI RAM between JTAG debug commands and the Avalon debug slave.
module nios2_cpu_ocimem_arbiter
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int JTAG_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [JDO_W-1:0]      jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    input  logic                  take_no_action_ocimem_a,
    nios2_cpu_ocimem_arbiter_if.slave avl,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_wr,
    output logic [OCI_DATA_W-1:0] ram_wdata,
    output logic [3:0]            ram_be,
    output logic                  ram_rd,
    input  logic [OCI_DATA_W-1:0] ram_rdata,
    output logic [OCI_DATA_W-1:0] MonDReg,
    output logic                  jtag_busy,
    output logic                  jtag_ovf
);
    ocimem_state_t state, state_next;

    logic [ADDR_W-1:0]     jtag_addr;
    logic [OCI_DATA_W-1:0] jtag_wdata;
    logic                  jrd_pend, jwr_pend, jtag_pend;
    logic                  waitrequest_q;
    logic [OCI_DATA_W-1:0] readdata_q;
    logic                  avl_req, req_j, req_a, gnt_j, gnt_a;
    logic                  any_strobe;

    logic                  ram_wr_d, ram_rd_d, waitrequest_d;
    logic [ADDR_W-1:0]     ram_addr_d;
    logic [OCI_DATA_W-1:0] ram_wdata_d;
    logic [3:0]            ram_be_d;

    logic                  jdo_unused;
    assign jdo_unused = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

    assign jtag_pend  = jrd_pend | jwr_pend;
    assign jtag_busy  = jtag_pend | is_jtag_state(state);
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // Read completion drops waitrequest one cycle while back in IDLE; masking
    // with the registered waitrequest stops that held request being re-granted.
    assign avl_req = (avl.read | avl.write) & waitrequest_q;
    assign req_j   = (state == IDLE) & jtag_pend;
    assign req_a   = (state == IDLE) & avl_req;

    assign avl.readdata    = readdata_q;
    assign avl.waitrequest = waitrequest_q;

    nios2_ocimem_rr_grant #(
        .JTAG_PRIO(JTAG_PRIO)
    ) u_grant (
        .clk    (clk),
        .reset_n(reset_n),
        .req_j  (req_j),
        .req_a  (req_a),
        .gnt_j  (gnt_j),
        .gnt_a  (gnt_a)
    );

    // Next state plus next values of the registered RAM/Avalon outputs
    always_comb begin
        state_next    = state;
        ram_wr_d      = 1'b0;
        ram_rd_d      = 1'b0;
        ram_addr_d    = ram_addr;
        ram_wdata_d   = ram_wdata;
        ram_be_d      = ram_be;
        waitrequest_d = 1'b1;
        unique case (state)
            IDLE: begin
                if (gnt_j) begin
                    ram_addr_d = jtag_addr;
                    ram_be_d   = '1;
                    if (jwr_pend) begin
                        state_next  = J_WR;
                        ram_wr_d    = 1'b1;
                        ram_wdata_d = jtag_wdata;
                    end else begin
                        state_next = J_RD;
                        ram_rd_d   = 1'b1;
                    end
                end else if (gnt_a) begin
                    ram_addr_d = avl.address;
                    ram_be_d   = avl.byteenable;
                    if (avl.write) begin
                        state_next    = A_WR;
                        ram_wr_d      = avl.debugaccess;
                        ram_wdata_d   = avl.writedata;
                        waitrequest_d = 1'b0;
                    end else begin
                        state_next = A_RD;
                        ram_rd_d   = 1'b1;
                    end
                end
            end
            J_WR:    state_next = IDLE;
            J_RD:    state_next = J_CAP;
            J_CAP:   state_next = IDLE;
            A_WR:    state_next = IDLE;
            A_RD:    state_next = A_CAP;
            A_CAP: begin
                state_next    = IDLE;
                waitrequest_d = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered RAM / waitrequest outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ram_wr        <= 1'b0;
            ram_rd        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_be        <= '0;
            waitrequest_q <= 1'b1;
        end else begin
            state         <= state_next;
            ram_wr        <= ram_wr_d;
            ram_rd        <= ram_rd_d;
            ram_addr      <= ram_addr_d;
            ram_wdata     <= ram_wdata_d;
            ram_be        <= ram_be_d;
            waitrequest_q <= waitrequest_d;
        end
    end

    // Capture RAM read data for whichever requester issued the read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
            MonDReg    <= '0;
        end else begin
            if (state == A_CAP) readdata_q <= ram_rdata;
            if (state == J_CAP) MonDReg    <= ram_rdata;
        end
    end

    // JTAG command decode, pending flags, auto-increment and overrun flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_addr  <= '0;
            jtag_wdata <= '0;
            jrd_pend   <= 1'b0;
            jwr_pend   <= 1'b0;
            jtag_ovf   <= 1'b0;
        end else begin
            if (state == J_WR || state == J_CAP) jtag_addr <= jtag_addr + 1'b1;
            if (gnt_j) begin
                jrd_pend <= 1'b0;
                jwr_pend <= 1'b0;
            end
            if (any_strobe) begin
                if (jtag_busy) begin
                    jtag_ovf <= 1'b1;
                end else if (take_action_ocimem_a) begin
                    jtag_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                    jrd_pend  <= jdo[JDO_RD_BIT];
                    jtag_ovf  <= 1'b0;
                end else if (take_action_ocimem_b) begin
                    jtag_wdata <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                    jwr_pend   <= 1'b1;
                end else begin
                    jrd_pend <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_nios2_cpu_ocimem_arbiter.sv
// Self-checking bench for the OCI RAM arbiter with a behavioural RAM.
module tb_nios2_cpu_ocimem_arbiter;
    import nios2_ocimem_pkg::*;

    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_a = 1'b0, take_b = 1'b0, take_n = 1'b0;
    logic [7:0]  ram_addr;
    logic        ram_wr, ram_rd;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [3:0]  ram_be;
    logic [31:0] mon;
    logic        busy, ovf;

    always #5 clk = ~clk;

    nios2_cpu_ocimem_arbiter_if #(.ADDR_W(ADDR_W)) avl ();

    nios2_cpu_ocimem_arbiter #(
        .ADDR_W   (ADDR_W),
        .JTAG_PRIO(0)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_a),
        .take_action_ocimem_b   (take_b),
        .take_no_action_ocimem_a(take_n),
        .avl                    (avl),
        .ram_addr               (ram_addr),
        .ram_wr                 (ram_wr),
        .ram_wdata              (ram_wdata),
        .ram_be                 (ram_be),
        .ram_rd                 (ram_rd),
        .ram_rdata              (ram_rdata),
        .MonDReg                (mon),
        .jtag_busy              (busy),
        .jtag_ovf               (ovf)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [31:0] pre(logic [7:0] a);
        return {16'hC0DE, a, ~a};
    endfunction

    // Behavioural single-port RAM, one cycle read latency
    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = pre(8'(i));
    always @(posedge clk) begin
        if (ram_wr)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    // Bus monitor and Avalon read-data scoreboard
    logic [31:0] sb [$];
    logic [7:0]  rd_log [$];
    int          wr_cnt = 0, wrq_low = 0, both_cnt = 0;
    logic [3:0]  last_be = '0;
    always @(posedge clk) begin
        #2;
        if (ram_wr) begin
            wr_cnt++;
            last_be = ram_be;
        end
        if (ram_rd) rd_log.push_back(ram_addr);
        if (ram_wr && ram_rd) both_cnt++;
        if (!avl.waitrequest) wrq_low++;
        if (!avl.waitrequest && avl.read && !avl.write) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL avl_rdata: got=%h want=<nothing queued>", avl.readdata);
            end else begin
                check("avl_rdata", avl.readdata, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(logic [7:0] a, logic rd);
        jdo = '0;
        jdo[JDO_ADDR_LSB +: ADDR_W] = a;
        jdo[JDO_RD_BIT] = rd;
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
    endtask

    task automatic pulse_b(logic [31:0] d);
        jdo = '0;
        jdo[JDO_WDATA_MSB:JDO_WDATA_LSB] = d;
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
    endtask

    task automatic pulse_n();
        take_n = 1'b1;
        tick();
        take_n = 1'b0;
    endtask

    task automatic wait_jtag(string name);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL %s: jtag_busy still high after %0d cycles, want low", name, n);
        end
    endtask

    task automatic avl_xfer(logic wr, logic [7:0] a, logic [31:0] d, logic [3:0] be,
                            logic dbg, output int lat);
        avl.address     = a;
        avl.write       = wr;
        avl.read        = ~wr;
        avl.writedata   = d;
        avl.byteenable  = be;
        avl.debugaccess = dbg;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (avl.waitrequest && lat < 40);
        if (avl.waitrequest) begin
            total++;
            bad++;
            $display("FAIL avl_timeout: waitrequest still high after %0d cycles", lat);
        end
        tick();
        avl.read  = 1'b0;
        avl.write = 1'b0;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_ram_wr"}, 32'(ram_wr), 0);
        check({tag, "_ram_rd"}, 32'(ram_rd), 0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
        check({tag, "_ram_be"}, 32'(ram_be), 0);
        check({tag, "_waitreq"}, 32'(avl.waitrequest), 1);
        check({tag, "_readdata"}, avl.readdata, 0);
        check({tag, "_mondreg"}, mon, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
    endtask

    typedef enum {K_JW, K_JR, K_AW, K_AR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        dbg;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        int lat, w0, q0;
        logic [7:0] r0, r1;

        vecs[0]  = '{K_AW, 8'h20, 32'h12345678, 4'hF,    1'b1, 32'h0};
        vecs[1]  = '{K_AR, 8'h20, 32'h0,        4'hF,    1'b0, 32'h12345678};
        vecs[2]  = '{K_AW, 8'h21, 32'hAABBCCDD, 4'b0011, 1'b1, 32'h0};
        vecs[3]  = '{K_AR, 8'h21, 32'h0,        4'hF,    1'b0, 32'hC0DECCDD};
        vecs[4]  = '{K_AW, 8'h22, 32'hFFFFFFFF, 4'hF,    1'b0, 32'h0};
        vecs[5]  = '{K_AR, 8'h22, 32'h0,        4'hF,    1'b0, 32'hC0DE22DD};
        vecs[6]  = '{K_JR, 8'h20, 32'h0,        4'hF,    1'b0, 32'h12345678};
        vecs[7]  = '{K_JW, 8'h30, 32'h0BADF00D, 4'hF,    1'b0, 32'h0};
        vecs[8]  = '{K_AR, 8'h30, 32'h0,        4'hF,    1'b0, 32'h0BADF00D};
        vecs[9]  = '{K_AW, 8'h31, 32'h01020304, 4'b1100, 1'b1, 32'h0};
        vecs[10] = '{K_JR, 8'h31, 32'h0,        4'hF,    1'b0, 32'h010231CE};

        avl.address = '0; avl.read = 1'b0; avl.write = 1'b0;
        avl.writedata = '0; avl.byteenable = '0; avl.debugaccess = 1'b0;

        repeat (3) tick();
        check_reset_vals("por");
        reset_n = 1'b1;
        tick();

        // JTAG write then read back, then auto-incremented address
        pulse_a(8'h10, 1'b0);
        pulse_b(32'hDEADBEEF);
        wait_jtag("jw_10");
        pulse_a(8'h10, 1'b1);
        wait_jtag("jr_10");
        check("jtag_rdback", mon, 32'hDEADBEEF);
        pulse_n();
        wait_jtag("jn_11");
        check("jaddr_after_rd", mon, pre(8'h11));

        // Streaming reads across the address wrap
        pulse_a(8'hFF, 1'b0);
        pulse_n();
        wait_jtag("wrap_ff");
        check("wrap_ff", mon, pre(8'hFF));
        pulse_n();
        wait_jtag("wrap_00");
        check("wrap_00", mon, pre(8'h00));
        pulse_n();
        wait_jtag("wrap_01");
        check("wrap_01", mon, pre(8'h01));

        // Table of single transactions
        for (int i = 0; i < NV; i++) begin
            case (vecs[i].kind)
                K_JW: begin
                    pulse_a(vecs[i].addr, 1'b0);
                    w0 = wr_cnt;
                    pulse_b(vecs[i].data);
                    wait_jtag("tbl_jw");
                    check("tbl_jw_wrcnt", 32'(wr_cnt - w0), 1);
                    check("tbl_jw_be", 32'(last_be), 32'hF);
                end
                K_JR: begin
                    pulse_a(vecs[i].addr, 1'b1);
                    wait_jtag("tbl_jr");
                    check("tbl_jr_data", mon, vecs[i].exp);
                end
                K_AW: begin
                    w0 = wr_cnt;
                    q0 = wrq_low;
                    avl_xfer(1'b1, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].dbg, lat);
                    check("tbl_aw_lat", 32'(lat), 1);
                    check("tbl_aw_wrq_low", 32'(wrq_low - q0), 1);
                    check("tbl_aw_wrcnt", 32'(wr_cnt - w0), 32'(vecs[i].dbg));
                    if (vecs[i].dbg) check("tbl_aw_be", 32'(last_be), 32'(vecs[i].be));
                end
                K_AR: begin
                    sb.push_back(vecs[i].exp);
                    q0 = wrq_low;
                    avl_xfer(1'b0, vecs[i].addr, '0, 4'hF, 1'b0, lat);
                    check("tbl_ar_lat", 32'(lat), 3);
                    check("tbl_ar_wrq_low", 32'(wrq_low - q0), 1);
                end
                default: ;
            endcase
        end

        // Conflict 1: pointer favours JTAG first
        rd_log.delete();
        pulse_a(8'h40, 1'b1);
        sb.push_back(pre(8'h50));
        avl_xfer(1'b0, 8'h50, '0, 4'hF, 1'b0, lat);
        wait_jtag("conf1");
        check("conf1_mon", mon, pre(8'h40));
        check("conf1_nrd", 32'(rd_log.size()), 2);
        r0 = (rd_log.size() > 0) ? rd_log[0] : 8'hXX;
        r1 = (rd_log.size() > 1) ? rd_log[1] : 8'hXX;
        check("conf1_first", 32'(r0), 32'h40);
        check("conf1_second", 32'(r1), 32'h50);

        // Conflict 2: Avalon now wins
        rd_log.delete();
        pulse_a(8'h60, 1'b1);
        sb.push_back(pre(8'h70));
        avl_xfer(1'b0, 8'h70, '0, 4'hF, 1'b0, lat);
        wait_jtag("conf2");
        check("conf2_mon", mon, pre(8'h60));
        check("conf2_nrd", 32'(rd_log.size()), 2);
        r0 = (rd_log.size() > 0) ? rd_log[0] : 8'hXX;
        r1 = (rd_log.size() > 1) ? rd_log[1] : 8'hXX;
        check("conf2_first", 32'(r0), 32'h70);
        check("conf2_second", 32'(r1), 32'h60);

        // Overrun: write strobe while a read is pending
        w0 = wr_cnt;
        pulse_a(8'h80, 1'b1);
        pulse_b(32'h11112222);
        check("ovf_set", 32'(ovf), 1);
        wait_jtag("ovf_rd");
        check("ovf_sticky", 32'(ovf), 1);
        check("ovf_rd_data", mon, pre(8'h80));
        check("ovf_no_write", 32'(wr_cnt - w0), 0);
        pulse_a(8'h80, 1'b0);
        check("ovf_clear", 32'(ovf), 0);

        // Reset asserted during J_WR
        pulse_a(8'h90, 1'b0);
        pulse_b(32'h55AA55AA);
        tick();
        check("rst_jwr_active", 32'(ram_wr), 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        sb.push_back(pre(8'h90));
        avl_xfer(1'b0, 8'h90, '0, 4'hF, 1'b0, lat);
        check("rst_rd_lat", 32'(lat), 3);

        check("sb_drained", 32'(sb.size()), 0);
        check("rw_overlap", 32'(both_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
